// File: rtl/fetch_pkg.sv
// Shared constants and entry type for the instruction-fetch front end.
package fetch_pkg;

  localparam int INST_W = 32;
  localparam int PC_INC = 4;
  localparam int FETCH_ADDR_W = 8;
  localparam logic [INST_W-1:0] ECALL_INST = 32'h0000_0073;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [INST_W-1:0]       inst;
  } fetch_entry_t;

  function automatic logic is_ecall(input logic [INST_W-1:0] word);
    return word == ECALL_INST;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with flush, occupancy count and
// registered storage; the head entry is read straight from the storage array.
module fetch_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 40,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             valid_o,
  output logic             full_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty, full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign do_pop  = pop_i & ~empty & ~flush_i;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push_i & ~flush_i & (~full | do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign valid_o = ~empty;
  assign full_o  = full;
  assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC generation, redirect/ecall-halt control and
// a small FIFO toward decode. FETCH_BYPASS_EN adds an empty-FIFO bypass path.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int                ADDR_W   = 8,
  parameter  int                DEPTH    = 4,
  parameter  logic [ADDR_W-1:0] RESET_PC = '0,
  localparam int                CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic [31:0]       inst_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic [CNT_W-1:0]  count,
  output logic              halted
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              halted_q, halted_d;
  logic              fifo_valid, fifo_full, fifo_push, fifo_pop, push;
  entry_t            fifo_wdata, fifo_rdata;

  assign fifo_pop   = fifo_valid & out_ready;
  assign push       = ~halted_q & ~redirect_valid & (~fifo_full | fifo_pop);
  assign fifo_wdata = '{pc: pc_q, inst: inst_rdata};

`ifdef FETCH_BYPASS_EN
  logic bypass;

  // Empty FIFO: the fetched word is shown this cycle and only stored if not taken.
  assign bypass    = push & ~fifo_valid;
  assign fifo_push = push & ~(bypass & out_ready);
  assign out_valid = fifo_valid | bypass;
  assign out_inst  = bypass ? inst_rdata : fifo_rdata.inst;
  assign out_pc    = bypass ? pc_q : fifo_rdata.pc;
`else
  assign fifo_push = push;
  assign out_valid = fifo_valid;
  assign out_inst  = fifo_rdata.inst;
  assign out_pc    = fifo_rdata.pc;
`endif

  always_comb begin
    pc_d     = pc_q;
    halted_d = halted_q;
    if (redirect_valid) begin
      pc_d     = redirect_pc & ~ADDR_W'(3);
      halted_d = 1'b0;
    end else if (push) begin
      pc_d = pc_q + ADDR_W'(PC_INC);
      if (is_ecall(inst_rdata)) halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + INST_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .flush_i (redirect_valid),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_rdata),
    .valid_o (fifo_valid),
    .full_o  (fifo_full),
    .count_o (count)
  );

  assign inst_addr = pc_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: table-driven sequences checked against a
// queue-based reference model, plus directed PC-wrap and async-reset sequences.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  inst_addr, redirect_pc, out_pc;
  logic [31:0] inst_rdata, out_inst;
  logic        redirect_valid, out_valid, out_ready, halted;
  logic [2:0]  count;
  bit          ecall_en;

  logic [7:0]  inst_addr1, out_pc1;
  logic [31:0] inst_rdata1, out_inst1;
  logic        out_valid1, halted1;
  logic [2:0]  count1;
  logic        redirect_valid1 = 1'b0;
  logic [7:0]  redirect_pc1    = 8'h00;
  logic        out_ready1      = 1'b1;

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [7:0] a, input bit ec);
    if (ec && a == 8'h38) return 32'h0000_0073;
    return {16'hC0DE, 8'h00, a};
  endfunction

  assign inst_rdata  = memf(inst_addr, ecall_en);
  assign inst_rdata1 = memf(inst_addr1, 1'b0);

  fetch_queue dut (
    .clk(clk), .rst(rst), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .count(count), .halted(halted)
  );

  fetch_queue #(.RESET_PC(8'hF8)) dut_wrap (
    .clk(clk), .rst(rst), .inst_addr(inst_addr1), .inst_rdata(inst_rdata1),
    .redirect_valid(redirect_valid1), .redirect_pc(redirect_pc1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_inst(out_inst1),
    .out_pc(out_pc1), .count(count1), .halted(halted1)
  );

  typedef struct {
    logic [7:0]  pc;
    logic [31:0] inst;
  } ent_t;

  typedef struct {
    bit         do_rst;
    bit         ec;
    bit         rdy;
    bit         rv;
    logic [7:0] rpc;
    logic [7:0] e_addr;
    int         e_cnt;
    bit         e_halt;
  } vec_t;

  ent_t       sq[$];
  vec_t       tbl[$];
  logic [7:0] m_pc;
  bit         m_halted;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input bit r, input bit ec, input bit rdy, input bit rv,
                     input logic [7:0] rpc, input logic [7:0] ea, input int ecnt,
                     input bit eh);
    vec_t v;
    v.do_rst = r; v.ec = ec; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.e_addr = ea; v.e_cnt = ecnt; v.e_halt = eh;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    sq.delete();
    m_pc = 8'h00;
    m_halted = 1'b0;
  endtask

  // One cycle: drive inputs after the falling edge, check the settled state
  // against the model, advance the model, then wait for the next falling edge.
  task automatic step(input bit rdy, input bit rv, input logic [7:0] rpc);
    bit   pop, push;
    ent_t e;
    out_ready = rdy;
    redirect_valid = rv;
    redirect_pc = rpc;
    #1;
    chk("inst_addr", 32'(inst_addr), 32'(m_pc));
    chk("count", 32'(count), 32'(sq.size()));
    chk("out_valid", 32'(out_valid), 32'(sq.size() != 0));
    chk("halted", 32'(halted), 32'(m_halted));
    pop = (sq.size() != 0) && rdy;
    if (rv) begin
      sq.delete();
      m_pc = rpc & 8'hFC;
      m_halted = 1'b0;
    end else begin
      push = !m_halted && (sq.size() < 4 || pop);
      if (pop) begin
        chk("out_pc", 32'(out_pc), 32'(sq[0].pc));
        chk("out_inst", out_inst, sq[0].inst);
        void'(sq.pop_front());
      end
      if (push) begin
        e.pc = m_pc;
        e.inst = memf(m_pc, ecall_en);
        sq.push_back(e);
        if (e.inst == 32'h0000_0073) m_halted = 1'b1;
        m_pc = m_pc + 8'd4;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 8'h00;
    ecall_en = 1'b0;

    // straight-line fetch, one per cycle
    add(1,0,1,0,8'h00, 8'h00,0,0); add(0,0,1,0,8'h00, 8'h04,1,0);
    add(0,0,1,0,8'h00, 8'h08,1,0); add(0,0,1,0,8'h00, 8'h0C,1,0);
    // back-pressure to full, then drain
    add(1,0,0,0,8'h00, 8'h00,0,0); add(0,0,0,0,8'h00, 8'h04,1,0);
    add(0,0,0,0,8'h00, 8'h08,2,0); add(0,0,0,0,8'h00, 8'h0C,3,0);
    add(0,0,0,0,8'h00, 8'h10,4,0); add(0,0,0,0,8'h00, 8'h10,4,0);
    add(0,0,1,0,8'h00, 8'h10,4,0); add(0,0,1,0,8'h00, 8'h14,4,0);
    add(0,0,1,0,8'h00, 8'h18,4,0); add(0,0,1,0,8'h00, 8'h1C,4,0);
    add(0,0,1,0,8'h00, 8'h20,4,0);
    // redirect to 0x1E with three entries queued (pop in same cycle discarded)
    add(1,0,0,0,8'h00, 8'h00,0,0); add(0,0,0,0,8'h00, 8'h04,1,0);
    add(0,0,0,0,8'h00, 8'h08,2,0); add(0,0,1,1,8'h1E, 8'h0C,3,0);
    add(0,0,0,0,8'h00, 8'h1C,0,0); add(0,0,1,0,8'h00, 8'h20,1,0);
    add(0,0,1,0,8'h00, 8'h24,1,0);
    // ecall at 0x38 halts; redirect to 0 resumes
    add(1,1,1,1,8'h30, 8'h00,0,0); add(0,1,1,0,8'h00, 8'h30,0,0);
    add(0,1,1,0,8'h00, 8'h34,1,0); add(0,1,1,0,8'h00, 8'h38,1,0);
    add(0,1,1,0,8'h00, 8'h3C,1,1); add(0,1,1,0,8'h00, 8'h3C,0,1);
    add(0,1,1,1,8'h00, 8'h3C,0,1); add(0,1,1,0,8'h00, 8'h00,0,0);
    add(0,1,1,0,8'h00, 8'h04,1,0);

    @(negedge clk);
    foreach (tbl[i]) begin
      if (tbl[i].do_rst) do_reset();
      ecall_en = tbl[i].ec;
      chk("tbl_addr", 32'(inst_addr), 32'(tbl[i].e_addr));
      chk("tbl_count", 32'(count), 32'(tbl[i].e_cnt));
      chk("tbl_halted", 32'(halted), 32'(tbl[i].e_halt));
      step(tbl[i].rdy, tbl[i].rv, tbl[i].rpc);
    end
    ecall_en = 1'b0;

    // PC wrap on the RESET_PC=0xF8 instance, which always has out_ready=1
    do_reset();
    chk("wrap_addr0", 32'(inst_addr1), 32'h0000_00F8);
    chk("wrap_valid0", 32'(out_valid1), 32'd0);
    @(negedge clk);
    chk("wrap_addr1", 32'(inst_addr1), 32'h0000_00FC);
    chk("wrap_valid1", 32'(out_valid1), 32'd1);
    chk("wrap_pc1", 32'(out_pc1), 32'h0000_00F8);
    chk("wrap_inst1", out_inst1, 32'hC0DE_00F8);
    @(negedge clk);
    chk("wrap_addr2", 32'(inst_addr1), 32'h0000_0000);
    chk("wrap_pc2", 32'(out_pc1), 32'h0000_00FC);
    @(negedge clk);
    chk("wrap_addr3", 32'(inst_addr1), 32'h0000_0004);
    chk("wrap_pc3", 32'(out_pc1), 32'h0000_0000);
    chk("wrap_inst3", out_inst1, 32'hC0DE_0000);

    // asynchronous reset with the FIFO full, checked before the next clock edge
    do_reset();
    repeat (5) step(1'b0, 1'b0, 8'h00);
    chk("full_before_rst", 32'(count), 32'd4);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_addr", 32'(inst_addr), 32'h0000_0000);
    chk("arst_addr_wrap", 32'(inst_addr1), 32'h0000_00F8);
    @(negedge clk);
    rst = 1'b1;
    sq.delete();
    m_pc = 8'h00;
    m_halted = 1'b0;
    repeat (3) step(1'b1, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
